wr_ptr_flag_ctrl: RTL and testbench
===================================

# wr_ptr_flag_ctrl

Parametrised write-side pointer and flag controller for the DDR3/UART FIFOs, the next generation of the fixed 512-entry write-pointer block. It tracks the binary write address and a Gray-coded write pointer for the read side, and computes true occupancy against the returned read pointer. It drives full and programmable almost-full flags from that occupancy rather than from a free-running write counter. It adds sticky overflow detection and write acknowledge, and sits between the UART/DDR write client and the dual-port FIFO RAM.

## Interface
- ADDR_W, 9, RAM address width; depth DEPTH = 2**ADDR_W (512 by default)
- AFULL_RST, 508, reset value reported for almost-full when threshold port is tied to it (documentation only; threshold is a port)
- i_wr_clk  in  1  write clock; the block's only clock
- i_wr_rstn  in  1  synchronous, active-low reset, sampled on rising i_wr_clk
- i_wr_en  in  1  write request from client
- i_rd_gray  in  ADDR_W+1  Gray-coded read pointer from read side
- i_afull_thresh  in  ADDR_W+1  almost-full threshold in words
- i_clr_ovf  in  1  clears sticky overflow
- o_wr_addr  out  ADDR_W  RAM write address (binary pointer LSBs)
- o_wr_we  out  1  combinational RAM write strobe = i_wr_en & ~o_full
- o_wr_gray  out  ADDR_W+1  registered Gray write pointer to read side
- o_wr_cnt  out  ADDR_W+1  registered occupancy, 0..DEPTH
- o_full  out  1  registered full flag
- o_almost_full  out  1  registered almost-full flag
- o_wr_ack  out  1  registered, pulses one cycle after each accepted write
- o_overflow  out  1  sticky: write attempted while full

## Operation
- Accept: fire = i_wr_en & ~o_full. Writes while full are dropped, with no pointer change.
- bin_nxt = bin + fire, ADDR_W+1 bits, wraps modulo 2*DEPTH. o_wr_addr = bin[ADDR_W-1:0].
- o_wr_gray <= bin_nxt ^ (bin_nxt >> 1).
- rd_bin = gray-to-binary of the read pointer (direct input or synchronised copy, see Configuration).
- cnt_nxt = bin_nxt - rd_bin, taken modulo 2^(ADDR_W+1). o_wr_cnt <= cnt_nxt.
- o_full <= (cnt_nxt == DEPTH). This is equivalent to the Gray compare with the top two bits inverted.
- o_almost_full <= (cnt_nxt >= i_afull_thresh).
  - Threshold 0: almost-full is always 1 after the first post-reset edge.
  - Threshold > DEPTH: almost-full never asserts.
- Occupancy is pessimistic: read advances are seen late, never early. Flags never under-report.
- Overflow: set on i_wr_en & o_full. Cleared by i_clr_ovf. Simultaneous set and clear: set wins.
- o_wr_ack <= fire.
- Reset: bin, o_wr_gray, o_wr_cnt, o_full, o_almost_full, o_wr_ack and o_overflow all go to 0; sync stages also go to 0. A request asserted in the reset cycle is ignored. Reset mid-fill discards all occupancy, and the read side must be reset in the same cycle.

## Timing
- Flags and count are updated at the same edge as the write that changes them, with zero lag. After the DEPTH-th accepted write, o_full is 1 on the next cycle, so no extra write slot exists.
- o_wr_we is combinational from i_wr_en and registered o_full, so it is glitch-safe in one cycle.
- Read pointer to flag release latency:
  - Without sync: 1 cycle.
  - With sync: 3 cycles.
- Pointer wrap: at bin = 2*DEPTH-1 with a write, bin becomes 0 and occupancy stays correct modulo arithmetic.
- Simultaneous write and read advance while full: the write is blocked and full releases from the read only.

## Configuration
- WR_PTR_SYNC_EN
  - Defined: i_rd_gray passes through a two-flop synchroniser clocked by i_wr_clk and reset to 0 before conversion.
  - Undefined: i_rd_gray is used directly, for the same-clock FIFO or an externally synchronised pointer.

## Structure
- Shared package `fifo_ptr_pkg`: default ADDR_W, and the functions bin2gray and gray2bin parametrised on width.
- One sub-module: `ptr_sync_2ff` (width parameter, synchronous active-low reset), instantiated only under WR_PTR_SYNC_EN.
- The rest is a single always block for pointer/flags plus one for overflow/ack.

## Test plan
- Reset with i_wr_en=1 and ADDR_W=9 -> all outputs 0; no write accepted in the reset cycle.
- 512 consecutive writes with i_rd_gray=0 and threshold 508 -> o_almost_full is set the cycle after write 508, o_full the cycle after write 512, o_wr_cnt=512, and o_wr_addr returns to 0.
- Write 513 while full -> o_wr_we=0, no ack, o_overflow=1 and held. i_clr_ovf together with a new blocked write -> overflow stays 1. i_clr_ovf alone -> 0.
- From full, read pointer advances by 4 (gray of 4) -> o_full drops and o_wr_cnt=508 after 1 cycle (3 with WR_PTR_SYNC_EN).
- Streaming 3000 writes with the read pointer trailing by 10 -> the pointer wraps past 1023 and o_wr_cnt stays 10, with no spurious full.
- Assert i_wr_rstn low at occupancy 300 -> next cycle count=0, full=0, gray=0, and writes resume at address 0.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// ============================================================================
// Module      : fifo_ptr_pkg
// Description : Shared FIFO pointer defaults and Gray/binary conversion helpers.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_ptr_pkg;

    localparam int ADDR_W_DEF = 9;
    // Helpers work on a fixed wide vector; callers zero-extend and truncate,
    // which is exact for any pointer width up to PTR_FN_W.
    localparam int PTR_FN_W   = 32;

    function automatic logic [PTR_FN_W-1:0] bin2gray(input logic [PTR_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_FN_W-1:0] gray2bin(input logic [PTR_FN_W-1:0] g);
        logic [PTR_FN_W-1:0] b;
        b[PTR_FN_W-1] = g[PTR_FN_W-1];
        for (int i = PTR_FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ptr_sync_2ff.sv
// ============================================================================
// Module      : ptr_sync_2ff
// Description : Two-flop synchroniser for a Gray pointer, sync active-low reset.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ptr_sync_2ff #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/wr_ptr_flag_ctrl.sv
// ============================================================================
// Module      : wr_ptr_flag_ctrl
// Description : FIFO write pointer, occupancy, full/almost-full, overflow, ack.
//               Define WR_PTR_SYNC_EN to synchronise i_rd_gray into i_wr_clk.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wr_ptr_flag_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AFULL_RST = 508
) (
    input  logic              i_wr_clk,
    input  logic              i_wr_rstn,
    input  logic              i_wr_en,
    input  logic [ADDR_W:0]   i_rd_gray,
    input  logic [ADDR_W:0]   i_afull_thresh,
    input  logic              i_clr_ovf,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_wr_we,
    output logic [ADDR_W:0]   o_wr_gray,
    output logic [ADDR_W:0]   o_wr_cnt,
    output logic              o_full,
    output logic              o_almost_full,
    output logic              o_wr_ack,
    output logic              o_overflow
);

    localparam int               PTR_W   = ADDR_W + 1;
    localparam int               DEPTH   = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] c_DEPTH = PTR_W'(DEPTH);

    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_gray;
    logic [PTR_W-1:0] r_cnt;
    logic             r_full;
    logic             r_afull;
    logic             r_ack;
    logic             r_ovf;

    logic [PTR_W-1:0] w_rd_gray;
    logic [PTR_W-1:0] w_rd_bin;
    logic [PTR_W-1:0] w_bin_nxt;
    logic [PTR_W-1:0] w_cnt_nxt;
    logic             w_fire;

`ifdef WR_PTR_SYNC_EN
    ptr_sync_2ff #(
        .WIDTH (PTR_W)
    ) u_rd_sync (
        .clk  (i_wr_clk),
        .rstn (i_wr_rstn),
        .i_d  (i_rd_gray),
        .o_q  (w_rd_gray)
    );
`else
    assign w_rd_gray = i_rd_gray;
`endif

    assign w_rd_bin  = PTR_W'(gray2bin(PTR_FN_W'(w_rd_gray)));
    assign w_fire    = i_wr_en & ~r_full;
    assign w_bin_nxt = r_bin + {{ADDR_W{1'b0}}, w_fire};
    // Modulo 2*DEPTH difference; read side may lag, so this only over-reports.
    assign w_cnt_nxt = w_bin_nxt - w_rd_bin;

    always_ff @(posedge i_wr_clk) begin
        if (!i_wr_rstn) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
        end else begin
            r_bin   <= w_bin_nxt;
            r_gray  <= PTR_W'(bin2gray(PTR_FN_W'(w_bin_nxt)));
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == c_DEPTH);
            r_afull <= (w_cnt_nxt >= i_afull_thresh);
        end
    end

    // A new blocked write takes priority over a clear in the same cycle.
    always_ff @(posedge i_wr_clk) begin
        if (!i_wr_rstn) begin
            r_ack <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_ack <= w_fire;
            if (i_wr_en && r_full) begin
                r_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_wr_addr     = r_bin[ADDR_W-1:0];
    assign o_wr_we       = w_fire;
    assign o_wr_gray     = r_gray;
    assign o_wr_cnt      = r_cnt;
    assign o_full        = r_full;
    assign o_almost_full = r_afull;
    assign o_wr_ack      = r_ack;
    assign o_overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_wr_ptr_flag_ctrl.sv
// ============================================================================
// Module      : tb_wr_ptr_flag_ctrl
// Description : Self-checking bench for wr_ptr_flag_ctrl with a scoreboard model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wr_ptr_flag_ctrl;

    localparam int ADDR_W = 9;
    localparam int PTR_W  = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MODV   = 2 * DEPTH;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PTR_W-1:0]  gray;
        logic [PTR_W-1:0]  cnt;
        logic              full;
        logic              af;
        logic              ack;
        logic              ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic              wr_en;
    logic [PTR_W-1:0]  rd_gray;
    logic [PTR_W-1:0]  thresh;
    logic              clr_ovf;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_we;
    logic [PTR_W-1:0]  wr_gray;
    logic [PTR_W-1:0]  wr_cnt;
    logic              full;
    logic              almost_full;
    logic              wr_ack;
    logic              overflow;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    int   rd_bin = 0;
    int   m_bin  = 0;
    int   m_cnt  = 0;
    logic m_full = 1'b0;
    logic m_af   = 1'b0;
    logic m_ack  = 1'b0;
    logic m_ovf  = 1'b0;
    int   m_s1   = 0;
    int   m_s2   = 0;

    wr_ptr_flag_ctrl #(
        .ADDR_W    (ADDR_W),
        .AFULL_RST (508)
    ) dut (
        .i_wr_clk       (clk),
        .i_wr_rstn      (rstn),
        .i_wr_en        (wr_en),
        .i_rd_gray      (rd_gray),
        .i_afull_thresh (thresh),
        .i_clr_ovf      (clr_ovf),
        .o_wr_addr      (wr_addr),
        .o_wr_we        (wr_we),
        .o_wr_gray      (wr_gray),
        .o_wr_cnt       (wr_cnt),
        .o_full         (full),
        .o_almost_full  (almost_full),
        .o_wr_ack       (wr_ack),
        .o_overflow     (overflow)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, check the write strobe, predict, push, then compare.
    task automatic cycle(input logic wr, input logic clr);
        exp_t e;
        exp_t got;
        int   seen;
        int   g;
        logic fire;
        wr_en   = wr;
        clr_ovf = clr;
        g       = rd_bin ^ (rd_bin >> 1);
        rd_gray = g[PTR_W-1:0];
        #1;
        fire = rstn && wr && !m_full;
        if (rstn) begin
            n_tests++;
            if (wr_we !== fire) begin
                n_fail++;
                $display("FAIL wr_we: got %b expected %b at t=%0t", wr_we, fire, $time);
            end
        end
`ifdef WR_PTR_SYNC_EN
        seen = m_s2;
`else
        seen = rd_bin;
`endif
        if (!rstn) begin
            m_bin = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ack = 0; m_ovf = 0;
            m_s1 = 0; m_s2 = 0;
        end else begin
            m_ovf  = (wr && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_ack  = fire;
            m_bin  = (m_bin + (fire ? 1 : 0)) % MODV;
            m_cnt  = (m_bin - seen + MODV) % MODV;
            m_full = (m_cnt == DEPTH);
            m_af   = (m_cnt >= int'(thresh));
            m_s2   = m_s1;
            m_s1   = rd_bin;
        end
        e.addr = ADDR_W'(m_bin);
        e.gray = PTR_W'(m_bin ^ (m_bin >> 1));
        e.cnt  = PTR_W'(m_cnt);
        e.full = m_full;
        e.af   = m_af;
        e.ack  = m_ack;
        e.ovf  = m_ovf;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        n_tests++;
        if ({wr_addr, wr_gray, wr_cnt, full, almost_full, wr_ack, overflow} !== got) begin
            n_fail++;
            $display("FAIL outputs t=%0t: got addr=%0d gray=%h cnt=%0d full=%b af=%b ack=%b ovf=%b expected addr=%0d gray=%h cnt=%0d full=%b af=%b ack=%b ovf=%b",
                     $time, wr_addr, wr_gray, wr_cnt, full, almost_full, wr_ack, overflow,
                     got.addr, got.gray, got.cnt, got.full, got.af, got.ack, got.ovf);
        end
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        rd_bin = 0;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        n_tests++;
        if (wr_cnt !== '0 || wr_addr !== '0 || wr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got cnt=%0d addr=%0d ack=%b expected 0 0 0", wr_cnt, wr_addr, wr_ack);
        end
        rstn = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0);
            if (i == 507 || i == 508) begin
                n_tests++;
                if (almost_full !== (i == 508)) begin
                    n_fail++;
                    $display("FAIL afull_edge write %0d: got %b expected %b", i, almost_full, (i == 508));
                end
            end
            if (i == DEPTH - 1) begin
                n_tests++;
                if (full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_full: got %b expected 0", full);
                end
            end
        end
        n_tests++;
        if (full !== 1'b1 || wr_cnt !== PTR_W'(DEPTH) || wr_addr !== '0) begin
            n_fail++;
            $display("FAIL full_state: got full=%b cnt=%0d addr=%0d expected 1 %0d 0", full, wr_cnt, wr_addr, DEPTH);
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got %b expected 1", overflow);
        end
        cycle(1'b0, 1'b1);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_read_release();
        int k;
        int exp_lat;
`ifdef WR_PTR_SYNC_EN
        exp_lat = 3;
`else
        exp_lat = 1;
`endif
        rd_bin = 4;
        k = 0;
        for (int j = 1; j <= 6; j++) begin
            cycle(1'b0, 1'b0);
            if (full === 1'b0) begin
                k = j;
                break;
            end
        end
        n_tests++;
        if (k != exp_lat || wr_cnt !== PTR_W'(508)) begin
            n_fail++;
            $display("FAIL release_latency: got %0d cycles cnt=%0d expected %0d cycles cnt=508", k, wr_cnt, exp_lat);
        end
    endtask

    task automatic test_back_to_back();
        int full_seen;
        rstn   = 1'b0;
        rd_bin = 0;
        cycle(1'b0, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        full_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            rd_bin = (m_bin - 9 + MODV) % MODV;
            cycle(1'b1, 1'b0);
            if (full === 1'b1) full_seen++;
        end
        n_tests++;
        if (full_seen != 0) begin
            n_fail++;
            $display("FAIL stream_full: got %0d full cycles expected 0", full_seen);
        end
    endtask

    task automatic test_mid_reset();
        rstn   = 1'b0;
        rd_bin = 0;
        cycle(1'b0, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0);
        rstn = 1'b0;
        cycle(1'b1, 1'b0);
        n_tests++;
        if (wr_cnt !== '0 || full !== 1'b0 || wr_gray !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got cnt=%0d full=%b gray=%h expected 0 0 0", wr_cnt, full, wr_gray);
        end
        rstn = 1'b1;
        n_tests++;
        if (wr_addr !== '0) begin
            n_fail++;
            $display("FAIL resume_addr: got %0d expected 0", wr_addr);
        end
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        thresh = '0;
        cycle(1'b0, 1'b0);
        thresh = PTR_W'(600);
        cycle(1'b0, 1'b0);
        thresh = PTR_W'(508);
    endtask

    initial begin
        rstn    = 1'b0;
        wr_en   = 1'b1;
        clr_ovf = 1'b0;
        rd_gray = '0;
        thresh  = PTR_W'(508);
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
